ccr_ctrl: RTL and testbench
===========================

Name: ccr_ctrl

Overview:
- Controls the 4-bit condition code register (Z,N,C,V) for the CPU core.
- Merges per-flag masked ALU updates with explicit SETC/CLRC.
- Saves and restores flags across nested interrupts using a LIFO shadow stack.
- Evaluates branch conditions against the committed flags with registered results; sits between the execute stage, the interrupt sequencer and branch resolution.

Parameters:
- SHADOW_DEPTH, 2, number of nested interrupt flag contexts held (1..8).
- PTR_W, 2, stack pointer width; must satisfy 2^PTR_W > SHADOW_DEPTH.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU flag result present this cycle.
- alu_flags  in  4  {V,C,N,Z} from ALU; bit0=Z, bit1=N, bit2=C, bit3=V.
- alu_mask  in  4  per-flag update enable; same bit order as alu_flags.
- setc  in  1  force C=1.
- clrc  in  1  force C=0.
- int_save  in  1  interrupt entry pulse; push flags.
- rti_restore  in  1  return-from-interrupt pulse; pop flags.
- br_eval  in  1  request branch condition evaluation.
- br_cond  in  3  condition select.
- ccr  out  4  committed flags.
- br_valid  out  1  branch result valid, one cycle after br_eval.
- br_taken  out  1  branch decision, qualified by br_valid.
- shadow_empty  out  1  stack pointer == 0.
- shadow_full  out  1  stack pointer == SHADOW_DEPTH.
- stk_ovf  out  1  sticky: push attempted while full.
- stk_unf  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async): ccr=0000, sp=0, all shadow entries=0, br_valid=0, br_taken=0, stk_ovf=0, stk_unf=0. shadow_empty=1 and shadow_full=0 follow from sp.
- Reset asserted mid-operation discards all saved contexts.
- Per-cycle next flags (nxt), highest priority first:
  1. rti_restore with sp>0: nxt = shadow[sp-1]; sp decrements. All concurrent ALU, setc, clrc and int_save inputs are discarded.
  2. Otherwise, base value:
     - base = ccr.
     - If alu_valid, bits with alu_mask=1 take alu_flags; other bits hold.
  3. Then setc sets C=1; else clrc clears C=0. If setc and clrc are both high, setc wins.
     - setc/clrc override the ALU C value in the same cycle.
  4. int_save with sp<SHADOW_DEPTH: push nxt into shadow[sp]; sp increments.
     - The pushed value includes same-cycle ALU and setc/clrc effects.
  - ccr <= nxt every cycle; flags change only at the clock edge.
  - An ALU write with alu_mask=0000 is a no-op.
- Boundary cases:
  - rti_restore with sp=0: stk_unf<=1; no pop; ccr follows rule 2/3 as if rti were absent; int_save in the same cycle is still honoured.
  - int_save with sp=SHADOW_DEPTH: stk_ovf<=1; no push; ccr still updates normally.
  - rti_restore and int_save together with sp>0: rti wins, save dropped, no error flagged.
  - stk_ovf and stk_unf clear only on rst.
- Branch evaluation:
  - Latency 1. On br_eval at edge N, br_valid=1 and br_taken are registered at edge N+1, evaluated against ccr as it is before edge N's update (no bypass).
  - br_valid=0 in every cycle without a prior br_eval; br_taken holds its last value when br_valid=0.
  - br_cond encoding:
    - 000 always
    - 001 Z
    - 010 N
    - 011 C
    - 100 V
    - 101 !Z
    - 110 !C
    - 111 never

Decomposition:
- Package ccr_pkg: flag bit index constants (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3) and br_cond encodings (BR_ALW, BR_Z, BR_N, BR_C, BR_V, BR_NZ, BR_NC, BR_NEV).
- One sub-module: ccr_shadow_stack.
  - Owns the entry array, sp, full/empty and the sticky error bits.
  - Interface: push, pop, push_data, pop_data.
- ccr_ctrl keeps the priority merge, the ccr register and the branch evaluator.

Test Plan:
1. Reset, then alu_valid=1, alu_flags=1111, alu_mask=0101 -> ccr=0101 after one edge. Next, alu_mask=0000 -> ccr stays 0101.
2. ccr=0000; alu_valid=1, alu_flags=0000, alu_mask=1111, with setc=1 in the same cycle -> ccr=0100. Then setc=1 and clrc=1 together -> C stays 1.
3. ccr=0001; int_save and alu update to 1000 (mask 1111) in the same cycle -> ccr=1000, shadow[0]=1000, sp=1. Change ccr to 0010, then rti_restore -> ccr=1000, shadow_empty=1.
4. SHADOW_DEPTH=2: three int_save pulses -> shadow_full=1 after the second, stk_ovf=1 after the third, sp=2. Three rti_restore pulses -> third sets stk_unf=1; ccr equals the first saved value.
5. ccr=0001: br_eval with br_cond=001 -> br_valid=1, br_taken=1 next cycle. Same cycle ALU sets Z=0, then br_eval with 101 -> taken=1 (new flags). br_cond=111 -> taken=0.
6. Assert rst asynchronously mid-cycle with sp=1 and ccr=1010 -> ccr=0000, sp=0, stk_ovf=0 and stk_unf=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ccr_pkg.sv
// Condition code register shared definitions: flag bit positions, branch condition
// encodings and the branch condition evaluator used by the controller.
package ccr_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam logic [2:0] BR_ALW = 3'b000;
    localparam logic [2:0] BR_Z   = 3'b001;
    localparam logic [2:0] BR_N   = 3'b010;
    localparam logic [2:0] BR_C   = 3'b011;
    localparam logic [2:0] BR_V   = 3'b100;
    localparam logic [2:0] BR_NZ  = 3'b101;
    localparam logic [2:0] BR_NC  = 3'b110;
    localparam logic [2:0] BR_NEV = 3'b111;

    function automatic logic br_cond_met(input logic [2:0] cond, input logic [3:0] flags);
        logic met;
        met = 1'b0;
        case (cond)
            BR_ALW: met = 1'b1;
            BR_Z:   met = flags[FLAG_Z];
            BR_N:   met = flags[FLAG_N];
            BR_C:   met = flags[FLAG_C];
            BR_V:   met = flags[FLAG_V];
            BR_NZ:  met = !flags[FLAG_Z];
            BR_NC:  met = !flags[FLAG_C];
            default: met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/ccr_ctrl_if.sv
// Flag update, interrupt save/restore and branch evaluation signals of the CCR controller.
// master drives requests (execute stage / sequencer), slave is the controller.
interface ccr_ctrl_if;
    logic       alu_valid;
    logic [3:0] alu_flags;
    logic [3:0] alu_mask;
    logic       setc;
    logic       clrc;
    logic       int_save;
    logic       rti_restore;
    logic       br_eval;
    logic [2:0] br_cond;
    logic [3:0] ccr;
    logic       br_valid;
    logic       br_taken;
    logic       shadow_empty;
    logic       shadow_full;
    logic       stk_ovf;
    logic       stk_unf;

    modport master (
        output alu_valid, alu_flags, alu_mask, setc, clrc, int_save, rti_restore,
               br_eval, br_cond,
        input  ccr, br_valid, br_taken, shadow_empty, shadow_full, stk_ovf, stk_unf
    );

    modport slave (
        input  alu_valid, alu_flags, alu_mask, setc, clrc, int_save, rti_restore,
               br_eval, br_cond,
        output ccr, br_valid, br_taken, shadow_empty, shadow_full, stk_ovf, stk_unf
    );
endinterface

// File: rtl/ccr_shadow_stack.sv
// LIFO of saved flag contexts with sticky overflow/underflow; pop wins over push.
// Push/pop take effect at the clock edge; pop_data is combinational from the top entry.
module ccr_shadow_stack #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] push_data,
    output logic [3:0] pop_data,
    output logic       empty,
    output logic       full,
    output logic       ovf,
    output logic       unf
);

    // Sized to the full pointer range so every pointer value is a legal index.
    logic [3:0]       mem [0:(1<<PTR_W)-1];
    logic [PTR_W-1:0] sp;
    logic             do_pop;
    logic             do_push;

    assign empty    = (sp == '0);
    assign full     = (sp == PTR_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && !full && !do_pop;
    assign pop_data = mem[sp - PTR_W'(1)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            for (int i = 0; i < (1 << PTR_W); i++) begin
                mem[i] <= 4'b0000;
            end
        end else begin
            if (do_pop) begin
                sp <= sp - PTR_W'(1);
            end else if (do_push) begin
                mem[sp] <= push_data;
                sp      <= sp + PTR_W'(1);
            end
            // A push dropped because a valid pop won the cycle is not an overflow.
            if (push && full && !do_pop) begin
                ovf <= 1'b1;
            end
            if (pop && empty) begin
                unf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccr_ctrl.sv
// Condition code register: masked ALU merge, SETC/CLRC, interrupt shadow stack, branch eval.
// Flags update at each edge; branch result is registered one cycle after br_eval; no backpressure.
module ccr_ctrl
    import ccr_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2,
    parameter int PTR_W        = 2
) (
    input  logic       clk,
    input  logic       rst,
    ccr_ctrl_if.slave  bus
);

    logic [3:0] ccr_q;
    logic [3:0] merged;
    logic [3:0] nxt;
    logic [3:0] pop_data;
    logic       empty;
    logic       br_valid_q;
    logic       br_taken_q;

    always_comb begin
        merged = ccr_q;
        if (bus.alu_valid) begin
            merged = (ccr_q & ~bus.alu_mask) | (bus.alu_flags & bus.alu_mask);
        end
        if (bus.setc) begin
            merged[FLAG_C] = 1'b1;
        end else if (bus.clrc) begin
            merged[FLAG_C] = 1'b0;
        end
    end

    // A restore with nothing saved falls back to the normal merge path.
    assign nxt = (bus.rti_restore && !empty) ? pop_data : merged;

    ccr_shadow_stack #(
        .DEPTH (SHADOW_DEPTH),
        .PTR_W (PTR_W)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.int_save),
        .pop       (bus.rti_restore),
        .push_data (merged),
        .pop_data  (pop_data),
        .empty     (empty),
        .full      (bus.shadow_full),
        .ovf       (bus.stk_ovf),
        .unf       (bus.stk_unf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccr_q      <= 4'b0000;
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            ccr_q      <= nxt;
            br_valid_q <= bus.br_eval;
            if (bus.br_eval) begin
                br_taken_q <= br_cond_met(bus.br_cond, ccr_q);
            end
        end
    end

    assign bus.ccr          = ccr_q;
    assign bus.shadow_empty = empty;
    assign bus.br_valid     = br_valid_q;
    assign bus.br_taken     = br_taken_q;

endmodule

// File: tb/tb_ccr_ctrl.sv
// Bench for ccr_ctrl: directed scenarios plus random traffic against a scoreboard model.
module tb_ccr_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ccr_ctrl_if bus ();

    ccr_ctrl #(.SHADOW_DEPTH(2), .PTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ccr;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
        logic       bv;
        logic       bt;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_ccr;
    logic [3:0] m_stk[$];
    logic       m_ovf;
    logic       m_unf;
    logic       m_bt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_flags   = 4'b0000;
        bus.alu_mask    = 4'b0000;
        bus.setc        = 1'b0;
        bus.clrc        = 1'b0;
        bus.int_save    = 1'b0;
        bus.rti_restore = 1'b0;
        bus.br_eval     = 1'b0;
        bus.br_cond     = 3'b000;
    endtask

    task automatic model_reset();
        m_ccr = 4'b0000;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_bt  = 1'b0;
    endtask

    function automatic logic ref_cond(input logic [2:0] c, input logic [3:0] f);
        // f = {V,C,N,Z}
        case (c)
            3'd0: return 1'b1;
            3'd1: return f[0];
            3'd2: return f[1];
            3'd3: return f[2];
            3'd4: return f[3];
            3'd5: return ~f[0];
            3'd6: return ~f[2];
            default: return 1'b0;
        endcase
    endfunction

    // Predict the post-edge state from the inputs now applied, then clock and compare.
    task automatic cycle();
        exp_t       e;
        logic [3:0] n;
        if (bus.br_eval) m_bt = ref_cond(bus.br_cond, m_ccr);
        if (bus.rti_restore && m_stk.size() > 0) begin
            n = m_stk.pop_back();
        end else begin
            if (bus.rti_restore) m_unf = 1'b1;
            n = m_ccr;
            if (bus.alu_valid)
                for (int b = 0; b < 4; b++) if (bus.alu_mask[b]) n[b] = bus.alu_flags[b];
            if (bus.setc) n[2] = 1'b1;
            else if (bus.clrc) n[2] = 1'b0;
            if (bus.int_save) begin
                if (m_stk.size() < 2) m_stk.push_back(n);
                else m_ovf = 1'b1;
            end
        end
        m_ccr   = n;
        e.ccr   = m_ccr;
        e.empty = (m_stk.size() == 0);
        e.full  = (m_stk.size() == 2);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.bv    = bus.br_eval;
        e.bt    = m_bt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_ccr",   bus.ccr,          e.ccr);
        chk("sb_empty", bus.shadow_empty, e.empty);
        chk("sb_full",  bus.shadow_full,  e.full);
        chk("sb_ovf",   bus.stk_ovf,      e.ovf);
        chk("sb_unf",   bus.stk_unf,      e.unf);
        chk("sb_bv",    bus.br_valid,     e.bv);
        if (e.bv) chk("sb_bt", bus.br_taken, e.bt);
    endtask

    task automatic alu(input logic [3:0] f, input logic [3:0] m);
        bus.alu_valid = 1'b1;
        bus.alu_flags = f;
        bus.alu_mask  = m;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        model_reset();
        rst = 1'b1;
        #12;
        chk("rst_ccr",   bus.ccr,          4'b0000);
        chk("rst_empty", bus.shadow_empty, 1'b1);
        chk("rst_full",  bus.shadow_full,  1'b0);
        chk("rst_ovf",   bus.stk_ovf,      1'b0);
        chk("rst_unf",   bus.stk_unf,      1'b0);
        chk("rst_bv",    bus.br_valid,     1'b0);
        chk("rst_bt",    bus.br_taken,     1'b0);
        #1 rst = 1'b0;

        // Masked ALU update and mask=0 no-op
        idle(); alu(4'b1111, 4'b0101); cycle();
        chk("t1_mask0101", bus.ccr, 4'b0101);
        idle(); alu(4'b1111, 4'b0000); cycle();
        chk("t1_mask0000", bus.ccr, 4'b0101);

        // SETC overrides ALU C; SETC beats CLRC
        idle(); alu(4'b0000, 4'b1111); bus.setc = 1'b1; cycle();
        chk("t2_setc", bus.ccr, 4'b0100);
        idle(); bus.setc = 1'b1; bus.clrc = 1'b1; cycle();
        chk("t2_setc_clrc", bus.ccr, 4'b0100);

        // Save includes same-cycle ALU result, restore brings it back
        idle(); alu(4'b0001, 4'b1111); cycle();
        idle(); alu(4'b1000, 4'b1111); bus.int_save = 1'b1; cycle();
        chk("t3_save_ccr", bus.ccr, 4'b1000);
        idle(); alu(4'b0010, 4'b1111); cycle();
        idle(); bus.rti_restore = 1'b1; cycle();
        chk("t3_rti_ccr", bus.ccr, 4'b1000);
        chk("t3_rti_empty", bus.shadow_empty, 1'b1);

        // Nesting to full, overflow, then underflow
        idle(); alu(4'b0011, 4'b1111); bus.int_save = 1'b1; cycle();
        idle(); alu(4'b0110, 4'b1111); bus.int_save = 1'b1; cycle();
        chk("t4_full", bus.shadow_full, 1'b1);
        idle(); bus.int_save = 1'b1; cycle();
        chk("t4_ovf", bus.stk_ovf, 1'b1);
        idle(); bus.rti_restore = 1'b1; cycle();
        chk("t4_pop1", bus.ccr, 4'b0110);
        idle(); bus.rti_restore = 1'b1; cycle();
        chk("t4_pop2", bus.ccr, 4'b0011);
        idle(); bus.rti_restore = 1'b1; cycle();
        chk("t4_unf", bus.stk_unf, 1'b1);
        chk("t4_unf_ccr", bus.ccr, 4'b0011);

        // Branch evaluation uses pre-update flags
        idle(); alu(4'b0001, 4'b1111); cycle();
        idle(); alu(4'b0000, 4'b0001); bus.br_eval = 1'b1; bus.br_cond = 3'b001; cycle();
        chk("t5_z_taken", bus.br_taken, 1'b1);
        idle(); bus.br_eval = 1'b1; bus.br_cond = 3'b101; cycle();
        chk("t5_nz_taken", bus.br_taken, 1'b1);
        idle(); bus.br_eval = 1'b1; bus.br_cond = 3'b111; cycle();
        chk("t5_never", bus.br_taken, 1'b0);
        idle(); bus.br_eval = 1'b1; bus.br_cond = 3'b000; cycle();
        idle(); cycle();
        chk("t5_hold_bv", bus.br_valid, 1'b0);
        chk("t5_hold_bt", bus.br_taken, 1'b1);

        // Asynchronous reset mid-cycle with a saved context
        idle(); alu(4'b1010, 4'b1111); bus.int_save = 1'b1; cycle();
        chk("t6_pre_ccr", bus.ccr, 4'b1010);
        idle();
        #3 rst = 1'b1;
        #1;
        chk("t6_ccr",   bus.ccr,          4'b0000);
        chk("t6_empty", bus.shadow_empty, 1'b1);
        chk("t6_ovf",   bus.stk_ovf,      1'b0);
        chk("t6_unf",   bus.stk_unf,      1'b0);
        chk("t6_bt",    bus.br_taken,     1'b0);
        model_reset();
        #2 rst = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.alu_valid   = 1'($urandom_range(0, 1));
            bus.alu_flags   = 4'($urandom_range(0, 15));
            bus.alu_mask    = 4'($urandom_range(0, 15));
            bus.setc        = ($urandom_range(0, 3) == 0);
            bus.clrc        = ($urandom_range(0, 3) == 0);
            bus.int_save    = ($urandom_range(0, 3) == 0);
            bus.rti_restore = ($urandom_range(0, 3) == 0);
            bus.br_eval     = 1'($urandom_range(0, 1));
            bus.br_cond     = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
